// File: rtl/sopc_cap_debug_scan_master.sv
// sopc_cap_debug_scan_master
//
// Runs one virtual-JTAG scan per accepted command:
// UIR -> CDR -> SDR (DR_WIDTH bits) -> UDR -> RTI, then it presents the captured
// DR bits and the sampled IR status until the consumer takes them.
// vji_tck is derived from clk: each half-period lasts TCK_HALF clk cycles
// (a value of 0 behaves as 1). TDI and state changes happen on the clk cycle
// where vji_tck falls. TDO and IR status are sampled on the cycle where
// vji_tck rises.
//
// Ports
//   clk, reset_n              system clock, synchronous active-low reset
//   cmd_valid/ready/ir/data   scan command (IR value, DR value shifted LSB first)
//   rsp_valid/ready/data/ir   scan result (captured DR, IR status from UIR)
//   busy                      high whenever the FSM is outside IDLE
//   vji_tck/tdi/tdo           scan clock and serial data
//   vji_ir_in/ir_out          virtual IR driven / IR status returned
//   vji_uir..vji_rti          one-hot virtual JTAG state indicators
module sopc_cap_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int TH    = (TCK_HALF < 1) ? 1 : TCK_HALF;
    localparam int DIV_W = (TH > 1) ? $clog2(TH) : 1;
    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TH - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DR_WIDTH-1:0] shift_reg;
    logic              scanning;
    logic              half_done;
    logic              tck_rise;
    logic              tck_fall;
    logic              accept;

    assign accept    = cmd_valid && cmd_ready;
    assign scanning  = (state != S_IDLE) && (state != S_RSP);
    assign half_done = scanning && (div_cnt == DIV_LAST);
    assign tck_rise  = half_done && !vji_tck;
    assign tck_fall  = half_done && vji_tck;
    assign rsp_data  = shift_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        vji_uir   = 1'b0;
        vji_cdr   = 1'b0;
        vji_sdr   = 1'b0;
        vji_udr   = 1'b0;
        vji_rti   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = S_UIR;
            end
            S_UIR: begin
                vji_uir = 1'b1;
                if (tck_fall) state_nxt = S_CDR;
            end
            S_CDR: begin
                vji_cdr = 1'b1;
                if (tck_fall) state_nxt = S_SDR;
            end
            S_SDR: begin
                vji_sdr = 1'b1;
                if (tck_fall && (bit_cnt == '0)) state_nxt = S_UDR;
            end
            S_UDR: begin
                vji_udr = 1'b1;
                if (tck_fall) state_nxt = S_RTI;
            end
            S_RTI: begin
                vji_rti = 1'b1;
                if (tck_fall) state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            vji_tck   <= 1'b0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            rsp_ir    <= '0;
        end else begin
            if (accept) begin
                vji_ir_in <= cmd_ir;
                shift_reg <= cmd_data;
                div_cnt   <= '0;
                vji_tck   <= 1'b0;
            end

            // Half-period divider; leaving RTI on a fall also parks tck low.
            if (scanning) begin
                if (half_done) begin
                    div_cnt <= '0;
                    vji_tck <= ~vji_tck;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end

            if (tck_rise) begin
                if (state == S_SDR) shift_reg <= {vji_tdo, shift_reg[DR_WIDTH-1:1]};
                if (state == S_UIR) rsp_ir <= vji_ir_out;
            end

            // TDI presents the current bit 0 from the fall that enters SDR,
            // and each following fall inside SDR, so it is stable at every rise.
            if (tck_fall) begin
                if (state_nxt == S_SDR) vji_tdi <= shift_reg[0];
                else                    vji_tdi <= 1'b0;
                if (state == S_CDR) bit_cnt <= BIT_LAST;
                else if ((state == S_SDR) && (bit_cnt != '0)) bit_cnt <= bit_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sopc_cap_debug_scan_master.sv
module tb_sopc_cap_debug_scan_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]  cmd_ir, rsp_ir, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_data, rsp_data;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [1:0]  tdo_mode;

    // secondary instances with TCK_HALF = 0 and 1, sharing command inputs
    logic        s_cmd_valid, s_rsp_ready;
    logic [1:0]  s_cmd_ir;
    logic [37:0] s_cmd_data;
    logic        h0_cmd_ready, h0_rsp_valid, h0_busy, h0_tck, h0_tdi;
    logic        h0_uir, h0_cdr, h0_sdr, h0_udr, h0_rti;
    logic [1:0]  h0_rsp_ir, h0_ir_in;
    logic [37:0] h0_rsp_data;
    logic        h1_cmd_ready, h1_rsp_valid, h1_busy, h1_tck, h1_tdi;
    logic        h1_uir, h1_cdr, h1_sdr, h1_udr, h1_rti;
    logic [1:0]  h1_rsp_ir, h1_ir_in;
    logic [37:0] h1_rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);

    sopc_cap_debug_scan_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
        .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    sopc_cap_debug_scan_master #(.TCK_HALF(0)) dut_h0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(h0_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data),
        .rsp_valid(h0_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(h0_rsp_data), .rsp_ir(h0_rsp_ir),
        .busy(h0_busy), .vji_tck(h0_tck), .vji_tdi(h0_tdi), .vji_tdo(h0_tdi),
        .vji_ir_in(h0_ir_in), .vji_ir_out(2'b11),
        .vji_uir(h0_uir), .vji_cdr(h0_cdr), .vji_sdr(h0_sdr), .vji_udr(h0_udr), .vji_rti(h0_rti)
    );

    sopc_cap_debug_scan_master #(.TCK_HALF(1)) dut_h1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(h1_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data),
        .rsp_valid(h1_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(h1_rsp_data), .rsp_ir(h1_rsp_ir),
        .busy(h1_busy), .vji_tck(h1_tck), .vji_tdi(h1_tdi), .vji_tdo(h1_tdi),
        .vji_ir_in(h1_ir_in), .vji_ir_out(2'b11),
        .vji_uir(h1_uir), .vji_cdr(h1_cdr), .vji_sdr(h1_sdr), .vji_udr(h1_udr), .vji_rti(h1_rti)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [1:0]  mode;     // 0: tdo looped to tdi, 1: tdo tied 1, 2: tdo tied 0
        logic [1:0]  ir_out;
        logic [37:0] exp_data;
        logic [1:0]  exp_ir;
    } vec_t;

    vec_t tab[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] ir, input logic [37:0] d,
                           output int lat, output int sdr_n, output int hi_n);
        lat = 0; sdr_n = 0; hi_n = 0;
        @(negedge clk);
        cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 1000) begin
            if (vji_sdr) sdr_n++;
            if (vji_tck) hi_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int lat, sdr_n, hi_n, n;
        logic [37:0] snap;
        logic stable;
        int lat0, lat1, hi0, hi1;

        tab[0] = '{2'b01, 38'h2A_AAAA_AAAA, 2'd0, 2'b01, 38'h2A_AAAA_AAAA, 2'b01};
        tab[1] = '{2'b10, 38'h00_0000_0000, 2'd1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
        tab[2] = '{2'b11, 38'h12_3456_789A, 2'd0, 2'b11, 38'h12_3456_789A, 2'b11};
        tab[3] = '{2'b00, 38'h3F_FFFF_FFFF, 2'd2, 2'b01, 38'h00_0000_0000, 2'b01};

        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_data = '0;
        tdo_mode = 2'd0; vji_ir_out = '0;
        s_cmd_valid = 1'b0; s_rsp_ready = 1'b0; s_cmd_ir = '0; s_cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_ir", rsp_ir, 0);
        check("reset_tck_tdi", {vji_tck, vji_tdi}, 0);
        check("reset_ir_in", vji_ir_in, 0);
        check("reset_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // table-driven scans at default parameters
        for (int i = 0; i < 4; i++) begin
            tdo_mode = tab[i].mode;
            vji_ir_out = tab[i].ir_out;
            run_cmd(tab[i].ir, tab[i].data, lat, sdr_n, hi_n);
            check($sformatf("v%0d_latency", i), lat, 169);
            check($sformatf("v%0d_sdr_cycles", i), sdr_n, 152);
            check($sformatf("v%0d_tck_high_cycles", i), hi_n, 84);
            check($sformatf("v%0d_rsp_data", i), rsp_data, tab[i].exp_data);
            check($sformatf("v%0d_rsp_ir", i), rsp_ir, tab[i].exp_ir);
            check($sformatf("v%0d_ir_in", i), vji_ir_in, tab[i].ir);
            check($sformatf("v%0d_rsp_tck_tdi", i), {vji_tck, vji_tdi}, 0);
            consume();
            check($sformatf("v%0d_idle_after_rsp", i), {busy, rsp_valid, cmd_ready}, 3'b001);
        end

        // response held while rsp_ready low; queued cmd accepted 2 edges after handshake
        tdo_mode = 2'd0;
        @(negedge clk);
        cmd_ir = 2'b10; cmd_data = 38'h0F_0F0F_0F0F; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(n);
        check("hold_rsp_arrives", rsp_valid, 1);
        snap = rsp_data;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== snap) stable = 1'b0;
        end
        check("hold_rsp_stable", stable, 1);
        check("hold_rsp_data", snap, 38'h0F_0F0F_0F0F);
        @(negedge clk);
        cmd_ir = 2'b11; cmd_data = 38'h00_0000_00FF; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hs_edge_idle_not_accepted", {busy, cmd_ready}, 2'b01);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("next_edge_accepted", {busy, vji_ir_in}, 3'b111);
        wait_rsp(n);
        check("queued_cmd_data", rsp_data, 38'h00_0000_00FF);
        consume();

        // reset pulse in the middle of SDR, then a clean scan
        @(negedge clk);
        cmd_ir = 2'b01; cmd_data = 38'h2B_CDEF_0123; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!vji_sdr && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_sdr", vji_sdr, 1);
        repeat (17 * 4 + 2) @(posedge clk);
        #1;
        check("still_in_sdr", vji_sdr, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_idle", {busy, cmd_ready, rsp_valid}, 3'b010);
        check("abort_tck_tdi", {vji_tck, vji_tdi}, 0);
        check("abort_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
        run_cmd(2'b10, 38'h11_2233_4455, lat, sdr_n, hi_n);
        check("after_abort_latency", lat, 169);
        check("after_abort_data", rsp_data, 38'h11_2233_4455);
        consume();

        // command offered while busy is ignored
        @(negedge clk);
        cmd_ir = 2'b01; cmd_data = 38'h01_2345_6789; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        cmd_ir = 2'b10; cmd_data = 38'h3E_DCBA_9876; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("busy_ignore_ir_in", vji_ir_in, 2'b01);
        wait_rsp(n);
        check("busy_ignore_data", rsp_data, 38'h01_2345_6789);
        check("busy_ignore_ir_in_end", vji_ir_in, 2'b01);
        consume();

        // TCK_HALF = 0 and 1 both run a 2-cycle tck
        @(negedge clk);
        s_cmd_ir = 2'b01; s_cmd_data = 38'h15_5555_5555; s_cmd_valid = 1'b1;
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        lat0 = 0; lat1 = 0; hi0 = 0; hi1 = 0;
        for (int c = 1; c < 300 && (lat0 == 0 || lat1 == 0); c++) begin
            if (h0_rsp_valid && lat0 == 0) lat0 = c;
            if (h1_rsp_valid && lat1 == 0) lat1 = c;
            if (h0_tck) hi0++;
            if (h1_tck) hi1++;
            @(posedge clk); #1;
        end
        check("th0_latency", lat0, 85);
        check("th1_latency", lat1, 85);
        check("th0_tck_high_cycles", hi0, 42);
        check("th1_tck_high_cycles", hi1, 42);
        check("th0_rsp_data", h0_rsp_data, 38'h15_5555_5555);
        check("th1_rsp_data", h1_rsp_data, 38'h15_5555_5555);
        check("th_rsp_ir", {h0_rsp_ir, h1_rsp_ir}, 4'b1111);
        @(negedge clk);
        s_rsp_ready = 1'b1;
        @(posedge clk); #1;
        s_rsp_ready = 1'b0;
        check("th_idle", {h0_busy, h1_busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sopc_cap_debug_scan_master.md
SOPC_CAP_DEBUG_SCAN_MASTER -- requirements
Module: sopc_cap_debug_scan_master

Interface
REQ-001 SHALL provide parameter DR_WIDTH, default 38, scan data-register length in bits.
REQ-002 SHALL provide parameter IR_WIDTH, default 2, virtual-IR width.
REQ-003 SHALL provide parameter TCK_HALF, default 2, clk cycles per vji_tck half-period; value 0 SHALL be treated as 1.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  scan command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_ir  in  IR_WIDTH  virtual IR value to load.
REQ-009 cmd_data  in  DR_WIDTH  DR value to shift in, LSB first.
REQ-010 rsp_valid  out  1  scan result available.
REQ-011 rsp_ready  in  1  result consumed when rsp_valid && rsp_ready.
REQ-012 rsp_data  out  DR_WIDTH  DR bits captured from vji_tdo.
REQ-013 rsp_ir  out  IR_WIDTH  vji_ir_out sampled during UIR.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 vji_tck  out  1  generated scan clock.
REQ-016 vji_tdi  out  1  serial data to debug slave.
REQ-017 vji_tdo  in  1  serial data from debug slave.
REQ-018 vji_ir_in  out  IR_WIDTH  virtual IR driven to debug slave.
REQ-019 vji_ir_out  in  IR_WIDTH  IR status from debug slave.
REQ-020 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual JTAG state indicators.

Function
REQ-021 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
REQ-022 cmd_ready SHALL be high only in IDLE; handshake captures cmd_ir into vji_ir_in and cmd_data into a DR_WIDTH shift register; next cycle state = UIR.
REQ-023 vji_tck SHALL be low in IDLE/RSP; in UIR..RTI it starts low on state entry from IDLE and toggles every TCK_HALF clk cycles.
REQ-024 one "tck period" = low half then high half; state transitions and tdi updates SHALL occur only on the clk cycle where vji_tck falls.
REQ-025 UIR, CDR, UDR, RTI SHALL each last exactly one tck period; SDR SHALL last exactly DR_WIDTH tck periods, counted by a down-counter.
REQ-026 exactly one of vji_uir/cdr/sdr/udr/rti SHALL be high, matching current state; all low in IDLE/RSP.
REQ-027 in SDR vji_tdi SHALL equal shift-register bit 0; on each vji_tck rising edge vji_tdo SHALL enter at MSB and the register shift right one bit.
REQ-028 vji_tdi SHALL be 0 outside SDR.
REQ-029 rsp_ir SHALL load vji_ir_out on the vji_tck rising edge within UIR.
REQ-030 after RTI, state = RSP with rsp_valid high and rsp_data = shift register; both held stable until rsp_ready.
REQ-031 RSP handshake SHALL return to IDLE the next cycle; a command is accepted no earlier than the following cycle.
REQ-032 vji_ir_in SHALL hold the last accepted cmd_ir until the next accept.
REQ-033 latency: accept at cycle 0 -> rsp_valid first high at cycle 1 + (DR_WIDTH+4)*2*TCK_HALF (default: 169).
REQ-034 cmd_valid during busy SHALL be ignored with no side effects.

Reset
REQ-035 while reset_n low at a clk edge, state SHALL go to IDLE irrespective of current state, aborting any scan.
REQ-036 reset values: cmd_ready 1, rsp_valid 0, busy 0, rsp_data 0, rsp_ir 0, vji_tck 0, vji_tdi 0, vji_ir_in 0, all vji state strobes 0, counters 0.

Verification
REQ-037 defaults, cmd_ir=2'b01, cmd_data=38'h2A_AAAA_AAAA, vji_tdo looped to vji_tdi -> rsp_valid at cycle 169, rsp_data=38'h2A_AAAA_AAAA.
REQ-038 vji_tdo tied 1, vji_ir_out=2'b10 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir=2'b10; vji_sdr high exactly 38*4=152 cycles.
REQ-039 TCK_HALF=0 and TCK_HALF=1 -> both give vji_tck period 2 cycles, rsp_valid at cycle 85.
REQ-040 rsp_ready held low 10 cycles then pulsed -> rsp_data stable throughout; cmd_valid held high accepted exactly 2 cycles after the rsp handshake.
REQ-041 reset_n low for one cycle mid-SDR (bit 17) -> next cycle IDLE, vji_tck 0, all strobes 0, rsp_valid 0; new command then completes normally.
REQ-042 cmd_valid pulsed while busy with different cmd_ir -> ignored; vji_ir_in and rsp_data reflect only the first command.
